// File: rtl/ball_move_sched.sv
// Per-frame move scheduler: on the first vblank trigger, strobes each ball's move bit in turn, one pixel period each.
// Latency: trigger at clk T -> move[0] on the next pixpulse edge (T+4); a round spans NBALLS+1 pixel periods.
// No backpressure: balls sample move once per pixpulse; pause/speed/step_req only gate whether a round starts.
// Optional feature macro: BALL_SCHED_STEP_EN (single-step while paused); undefined -> step_req ignored.
module ball_move_sched #(
    parameter int NBALLS    = 2,
    parameter int TRIG_LINE = 480,
    parameter int SPD_W     = 4,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixpulse,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [SPD_W-1:0]  speed,
    input  logic              pause,
    input  logic              step_req,
    output logic [NBALLS-1:0] move,
    output logic              round_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy
);

    // idx runs 0..NBALLS inclusive; the value NBALLS is the "round finished" slot
    localparam int                IDX_W    = $clog2(NBALLS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBALLS);

    typedef enum logic {
        WAIT_TRIG = 1'b0,
        ISSUE     = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SPD_W-1:0]   div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NBALLS-1:0]  move_q, move_d;
    logic               round_done_q, round_done_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               step_pend_q;

    logic               trig;
    logic               start_round;
    logic               round_end;

    // trig already carries pixpulse, so every trig-driven update is pixel-rate qualified
    assign trig = pixpulse && (vcount == 10'(TRIG_LINE)) && (hcount == 10'd0);

    // ISSUE reaches the terminal slot: clears move and closes the round on this pixel edge
    assign round_end = (state_q == ISSUE) && pixpulse && !(idx_q < LAST_IDX);

    // Decide whether this trigger launches a round (only when idle); ">=" lets a speed drop act at once
    always_comb begin
        start_round = 1'b0;
        if ((state_q == WAIT_TRIG) && trig) begin
            if (pause) begin
                start_round = step_pend_q;
            end else begin
                start_round = (div_cnt_q >= speed);
            end
        end
    end

`ifdef BALL_SCHED_STEP_EN
    logic step_take;
    assign step_take = (state_q == WAIT_TRIG) && trig && pause && step_pend_q;

    // Capture step requests on any clk edge while paused; a new request wins over consumption
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_pend_q <= 1'b0;
        end else if (pause && step_req) begin
            step_pend_q <= 1'b1;
        end else if (step_take) begin
            step_pend_q <= 1'b0;
        end
    end
`else
    // Without single-step support a paused scheduler never starts a round
    logic step_req_unused;
    assign step_req_unused = step_req;
    assign step_pend_q     = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_TRIG;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: idle until a qualifying trigger, issue until the terminal slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_TRIG: if (start_round) state_d = ISSUE;
            ISSUE:     if (round_end)   state_d = WAIT_TRIG;
            default:                    state_d = WAIT_TRIG;
        endcase
    end

    // Datapath next values: divider, frame counter, ball index and move strobes
    always_comb begin
        div_cnt_d    = div_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        idx_d        = idx_q;
        move_d       = move_q;
        round_done_d = round_end;

        // every trigger is counted, even one that lands mid-round
        if (trig) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        // divider only advances on unpaused idle triggers; pause holds it
        if ((state_q == WAIT_TRIG) && trig && !pause) begin
            if (start_round) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        // one ball per pixel period, then a single all-zero slot to finish
        if ((state_q == ISSUE) && pixpulse) begin
            if (idx_q < LAST_IDX) begin
                move_d = NBALLS'(1) << idx_q;
                idx_d  = idx_q + 1'b1;
            end else begin
                move_d = '0;
                idx_d  = '0;
            end
        end
    end

    // Datapath registers; round_done clears on the very next clk so it is a 1-clk pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            idx_q        <= '0;
            move_q       <= '0;
            round_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            idx_q        <= idx_d;
            move_q       <= move_d;
            round_done_q <= round_done_d;
        end
    end

    // FSM outputs: busy follows the state register so reset drops it immediately
    always_comb begin
        move       = move_q;
        round_done = round_done_q;
        frame_cnt  = frame_cnt_q;
        busy       = (state_q == ISSUE);
    end

    // Move strobes must never overlap, and a finished round is never reported while still issuing
    a_move_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(move_q));
    a_done_idle:   assert property (@(posedge clk) disable iff (rst) round_done_q |-> (state_q == WAIT_TRIG));

endmodule
